score_display_ctrl: RTL and testbench

- Sequences the four HEX digit drivers of the pong scoreboard: left-player tens/ones and right-player tens/ones.
- Converts two binary scores to BCD with a multi-cycle shift-add-3 (double-dabble) FSM.
- Registers the resulting nibbles for four downstream seg7 decoders, plus a per-digit blank mask for leading-zero suppression.
- Top level forms each HEX as: blank ? 7'b1111111 : seg7 leds.

---
 rtl/score_display_ctrl_if.sv | 27 ++
 rtl/score_display_ctrl.sv | 133 +++++++++++++
 tb/tb_score_display_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_ctrl_if.sv
// Scoreboard display bus: binary scores and control in, BCD digits, blank mask and busy out.
interface score_display_ctrl_if #(
  parameter int unsigned SCORE_W = 7
);
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               update;
  logic               game_over;
  logic               busy;
  logic [3:0]         dig_lt;
  logic [3:0]         dig_lo;
  logic [3:0]         dig_rt;
  logic [3:0]         dig_ro;
  logic [3:0]         blank;

  // Score source / display consumer side
  modport master (
    output score_l, score_r, update, game_over,
    input  busy, dig_lt, dig_lo, dig_rt, dig_ro, blank
  );

  // Controller side
  modport slave (
    input  score_l, score_r, update, game_over,
    output busy, dig_lt, dig_lo, dig_rt, dig_ro, blank
  );
endinterface

// File: rtl/score_display_ctrl.sv
// Pong scoreboard digit sequencer: clamps two binary scores to 99, converts them to BCD with a
// multi-cycle double-dabble FSM and registers four digit nibbles plus a leading-zero blank mask.
// Optional feature: define SCORE_BLINK_EN to blank all digits periodically while game_over is high.
module score_display_ctrl #(
  parameter int unsigned SCORE_W    = 7,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input logic                 clk,
  input logic                 reset,
  score_display_ctrl_if.slave bus
);

  localparam int unsigned CntBits = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e             state_q;
  logic               pending_q;
  logic               busy_q;
  logic [CntBits-1:0] shift_cnt_q;
  logic [SCORE_W-1:0] bin_l_q;
  logic [SCORE_W-1:0] bin_r_q;
  logic [7:0]         bcd_l_q;
  logic [7:0]         bcd_r_q;
  logic [3:0]         dig_lt_q;
  logic [3:0]         dig_lo_q;
  logic [3:0]         dig_rt_q;
  logic [3:0]         dig_ro_q;
  logic [3:0]         lz_mask_q;
  logic               blink_phase;

  function automatic logic [SCORE_W-1:0] clamp99(input logic [SCORE_W-1:0] v);
    if (32'(v) > 32'd99) return SCORE_W'(99);
    return v;
  endfunction

  // Add 3 to any BCD nibble of 5 or more before the shift so it carries correctly.
  function automatic logic [7:0] add3(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  // Conversion FSM: latch, shift SCORE_W times, then commit digits to the display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      shift_cnt_q <= '0;
      bin_l_q     <= '0;
      bin_r_q     <= '0;
      bcd_l_q     <= '0;
      bcd_r_q     <= '0;
      dig_lt_q    <= '0;
      dig_lo_q    <= '0;
      dig_rt_q    <= '0;
      dig_ro_q    <= '0;
      lz_mask_q   <= 4'b1010;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.update || pending_q) begin
            bin_l_q     <= clamp99(bus.score_l);
            bin_r_q     <= clamp99(bus.score_r);
            bcd_l_q     <= '0;
            bcd_r_q     <= '0;
            shift_cnt_q <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StShift;
          end
        end
        StShift: begin
          // Requests while busy collapse into a single pending conversion.
          if (bus.update) pending_q <= 1'b1;
          {bcd_l_q, bin_l_q} <= {add3(bcd_l_q), bin_l_q} << 1;
          {bcd_r_q, bin_r_q} <= {add3(bcd_r_q), bin_r_q} << 1;
          shift_cnt_q <= shift_cnt_q + CntBits'(1);
          if (shift_cnt_q == CntBits'(SCORE_W - 1)) state_q <= StCommit;
        end
        StCommit: begin
          if (bus.update) pending_q <= 1'b1;
          dig_lt_q  <= bcd_l_q[7:4];
          dig_lo_q  <= bcd_l_q[3:0];
          dig_rt_q  <= bcd_r_q[7:4];
          dig_ro_q  <= bcd_r_q[3:0];
          // Only tens digits are suppressed so a zero score still shows "0".
          lz_mask_q <= {bcd_l_q[7:4] == 4'd0, 1'b0, bcd_r_q[7:4] == 4'd0, 1'b0};
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CntW-1:0] blink_cnt_q;
  logic            blink_phase_q;

  // Blink timer: free-runs only while game_over is high, toggling phase at each wrap.
  always_ff @(posedge clk) begin
    if (reset || !bus.game_over) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == CntW'(BLINK_HALF - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CntW'(1);
    end
  end

  assign blink_phase = blink_phase_q;
`else
  logic unused_blink;
  assign unused_blink = bus.game_over ^ (BLINK_HALF == 0);
  assign blink_phase  = 1'b0;
`endif

  assign bus.busy   = busy_q;
  assign bus.dig_lt = dig_lt_q;
  assign bus.dig_lo = dig_lo_q;
  assign bus.dig_rt = dig_rt_q;
  assign bus.dig_ro = dig_ro_q;
  assign bus.blank  = blink_phase ? 4'b1111 : lz_mask_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized self-checking bench for score_display_ctrl against a decimal-arithmetic model.
module tb_score_display_ctrl;

  localparam int unsigned ScoreW    = 7;
  localparam int unsigned BlinkHalf = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  score_display_ctrl_if #(.SCORE_W(ScoreW)) bus ();

  score_display_ctrl #(
    .SCORE_W    (ScoreW),
    .BLINK_HALF (BlinkHalf)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: clamp, then tens/ones by division.
  function automatic logic [15:0] model_digits(input int l, input int r);
    int cl, cr;
    cl = (l > 99) ? 99 : l;
    cr = (r > 99) ? 99 : r;
    return {4'(cl / 10), 4'(cl % 10), 4'(cr / 10), 4'(cr % 10)};
  endfunction

  function automatic logic [3:0] model_blank(input int l, input int r);
    int cl, cr;
    cl = (l > 99) ? 99 : l;
    cr = (r > 99) ? 99 : r;
    return {cl < 10, 1'b0, cr < 10, 1'b0};
  endfunction

  function automatic logic [15:0] shown();
    return {bus.dig_lt, bus.dig_lo, bus.dig_rt, bus.dig_ro};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse update and count the cycles busy stays high (bounded).
  task automatic run_conv(input int l, input int r, output int cyc);
    bus.score_l = ScoreW'(l);
    bus.score_r = ScoreW'(r);
    bus.update  = 1'b1;
    step();
    bus.update = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 50) begin
      cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.score_l = '0;
    bus.score_r = '0;
    bus.update = 1'b0;
    bus.game_over = 1'b0;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (shown() !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_digits: got %h want 0000", shown());
    end
    n_checks++;
    if (bus.blank !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_blank: got %b want 1010", bus.blank);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d;
    exp_d = model_digits(7, 42);
    bus.score_l = 7'd7;
    bus.score_r = 7'd42;
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_busy[%0d]: got %b want 1", i, bus.busy);
      end
      n_checks++;
      if (shown() !== 16'h0000 || bus.blank !== 4'b1010) begin
        n_fail++;
        $display("FAIL basic_stable[%0d]: got %h/%b want 0000/1010", i, shown(), bus.blank);
      end
      step();
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got busy %b want 0", bus.busy);
    end
    n_checks++;
    if (shown() !== exp_d || exp_d !== 16'h0742) begin
      n_fail++;
      $display("FAIL basic_digits: got %h want 0742", shown());
    end
    n_checks++;
    if (bus.blank !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_blank: got %b want 1000", bus.blank);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    run_conv(99, 120, cyc);
    n_checks++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL clamp_latency: got %0d want 8", cyc);
    end
    n_checks++;
    if (shown() !== 16'h9999) begin
      n_fail++;
      $display("FAIL clamp_digits: got %h want 9999", shown());
    end
    n_checks++;
    if (bus.blank !== 4'b0000) begin
      n_fail++;
      $display("FAIL clamp_blank: got %b want 0000", bus.blank);
    end
  endtask

  task automatic test_random();
    int l, r, cyc;
    for (int i = 0; i < 24; i++) begin
      l = int'($urandom_range(0, 127));
      r = int'($urandom_range(0, 127));
      if (i == 0) l = 0;
      if (i == 1) r = 127;
      run_conv(l, r, cyc);
      n_checks++;
      if (cyc != 8) begin
        n_fail++;
        $display("FAIL rand_latency(%0d,%0d): got %0d want 8", l, r, cyc);
      end
      n_checks++;
      if (shown() !== model_digits(l, r)) begin
        n_fail++;
        $display("FAIL rand_digits(%0d,%0d): got %h want %h", l, r, shown(), model_digits(l, r));
      end
      n_checks++;
      if (bus.blank !== model_blank(l, r)) begin
        n_fail++;
        $display("FAIL rand_blank(%0d,%0d): got %b want %b", l, r, bus.blank, model_blank(l, r));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.score_l = 7'd3;
    bus.score_r = 7'd5;
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    step();
    step();
    // Two requests during the first conversion must collapse into one follow-up.
    bus.score_l = 7'd11;
    bus.score_r = 7'd0;
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    step();
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 50) begin
      cyc++;
      step();
    end
    n_checks++;
    if (cyc != 3) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d want 3", cyc);
    end
    n_checks++;
    if (shown() !== model_digits(3, 5) || bus.blank !== model_blank(3, 5)) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%b want %h/%b", shown(), bus.blank,
               model_digits(3, 5), model_blank(3, 5));
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: got busy %b want 1", bus.busy);
    end
    n_checks++;
    if (shown() !== 16'h0305) begin
      n_fail++;
      $display("FAIL b2b_hold: got %h want 0305", shown());
    end
    cyc = 0;
    while (bus.busy && cyc < 50) begin
      cyc++;
      step();
    end
    n_checks++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d want 8", cyc);
    end
    n_checks++;
    if (shown() !== model_digits(11, 0) || bus.blank !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%b want 1100/0010", shown(), bus.blank);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_collapse[%0d]: got busy %b want 0", i, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.score_l = 7'd5;
    bus.score_r = 7'd10;
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (shown() !== 16'h0000 || bus.blank !== 4'b1010 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got %h/%b/%b want 0000/1010/0", shown(), bus.blank, bus.busy);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (shown() !== 16'h0000 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_quiet[%0d]: got %h/%b want 0000/0", i, shown(), bus.busy);
      end
    end
  endtask

  task automatic test_game_over();
    int cyc;
    logic [3:0] exp_b;
    run_conv(5, 10, cyc);
    n_checks++;
    if (shown() !== 16'h0510 || bus.blank !== 4'b1000) begin
      n_fail++;
      $display("FAIL go_setup: got %h/%b want 0510/1000", shown(), bus.blank);
    end
    bus.game_over = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
`ifdef SCORE_BLINK_EN
      exp_b = (((n / int'(BlinkHalf)) % 2) == 1) ? 4'b1111 : 4'b1000;
`else
      exp_b = 4'b1000;
`endif
      n_checks++;
      if (bus.blank !== exp_b || shown() !== 16'h0510) begin
        n_fail++;
        $display("FAIL go_blank[%0d]: got %b/%h want %b/0510", n, bus.blank, shown(), exp_b);
      end
    end
    bus.game_over = 1'b0;
    step();
    n_checks++;
    if (bus.blank !== 4'b1000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL go_clear: got %b/%b want 1000/0", bus.blank, bus.busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_clamp();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_game_over();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
